// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner peripheral.
//  status_t : layout of the CPU-visible status/data word.
//  ctrl_t   : layout of the control write word.
//  key_code : hex code for a row-major key index (* = E, # = F).
//  lowest_index : index of the lowest set bit in a 16-bit key map.
package keypad_pkg;

  localparam int unsigned KEYS      = 16;
  localparam int unsigned CODE_W    = 4;
  localparam int unsigned MAP_W     = 16;
  localparam int unsigned STAT_CNTW = 5;

  // Status/data word: [31] not empty, [30] overflow, [28:24] count,
  // [23:8] debounced map, [3:0] head code.
  typedef struct packed {
    logic                 not_empty;
    logic                 overflow;
    logic                 rsvd_29;
    logic [STAT_CNTW-1:0] count;
    logic [MAP_W-1:0]     key_map;
    logic [3:0]           rsvd_7_4;
    logic [CODE_W-1:0]    head_code;
  } status_t;

  // Control word: [0] flush FIFO, [1] clear overflow.
  typedef struct packed {
    logic [29:0] rsvd;
    logic        clr_ovf;
    logic        flush;
  } ctrl_t;

  // Row-major key legend: 1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D
  function automatic logic [CODE_W-1:0] key_code(input logic [3:0] idx);
    logic [CODE_W-1:0] code;
    case (idx)
      4'd0:    code = 4'h1;
      4'd1:    code = 4'h2;
      4'd2:    code = 4'h3;
      4'd3:    code = 4'hA;
      4'd4:    code = 4'h4;
      4'd5:    code = 4'h5;
      4'd6:    code = 4'h6;
      4'd7:    code = 4'hB;
      4'd8:    code = 4'h7;
      4'd9:    code = 4'h8;
      4'd10:   code = 4'h9;
      4'd11:   code = 4'hC;
      4'd12:   code = 4'hE;
      4'd13:   code = 4'h0;
      4'd14:   code = 4'hF;
      default: code = 4'hD;
    endcase
    return code;
  endfunction

  // Scan from the top so the lowest set bit is the one left standing.
  function automatic logic [3:0] lowest_index(input logic [MAP_W-1:0] v);
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < 16; i++) begin
      if (v[4'(15 - i)]) idx = 4'(15 - i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_scanner_module_fifo.sv
// keypad_fifo: synchronous key-code FIFO with flush.
//  clk, rst      : clock, synchronous active-high reset
//  push_i/data_i : write request and code
//  pop_i         : remove head (ignored when empty)
//  flush_i       : empty the FIFO; beats same-cycle push and pop
//  count_c_o     : occupancy, head_c_o : head code (0 when empty)
//  empty_c_o, full_c_o : occupancy flags
module keypad_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output logic [$clog2(DEPTH):0]   count_c_o,
  output logic [WIDTH-1:0]         head_c_o,
  output logic                     empty_c_o,
  output logic                     full_c_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             pop_ok_c, push_ok_c;

  // Pointers carry one extra bit so full and empty are distinguishable.
  assign count_c_o = wr_ptr_q - rd_ptr_q;
  assign empty_c_o = (count_c_o == '0);
  assign full_c_o  = (count_c_o == (AW+1)'(DEPTH));
  assign head_c_o  = empty_c_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  // A pop frees the slot a same-cycle push needs when full.
  assign pop_ok_c  = pop_i & ~empty_c_o;
  assign push_ok_c = push_i & (~full_c_o | pop_ok_c);

  // Pointer next-state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push_ok_c) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      if (pop_ok_c)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  // Pointer and storage registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (push_ok_c && !flush_i) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end
  end

endmodule

// File: rtl/keypad_scanner_module.sv
// keypad_scanner_module: 4x4 matrix keypad scanner with debounce and
// key-code FIFO, read over a simple strobe bus.
//  clk, rst          : clock, synchronous active-high reset
//  wr_en, wr_data    : control write ([0] flush FIFO, [1] clear overflow)
//  rd_en             : pop FIFO head
//  rd_data           : status/data word (combinational)
//  kp_col            : column drive, active-low one-hot
//  kp_row            : row sense, active-low, asynchronous
//  key_irq           : high while FIFO holds a code
module keypad_scanner_module
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_TICKS     = 10000,
  parameter int unsigned DEBOUNCE_SCANS = 4,
  parameter int unsigned FIFO_DEPTH     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [31:0] wr_data,
  input  logic        rd_en,
  output logic [31:0] rd_data,
  output logic [3:0]  kp_col,
  input  logic [3:0]  kp_row,
  output logic        key_irq
);

  localparam int unsigned TW = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
  localparam int unsigned DW = $clog2(DEBOUNCE_SCANS + 1);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_TICKS - 1);
  localparam logic [DW-1:0] DEB_MAX   = DW'(DEBOUNCE_SCANS);

  logic [3:0]        row_s1_q, row_s2_q;
  logic [TW-1:0]     tick_q, tick_d;
  logic [1:0]        col_q, col_d;
  logic [3:0]        kp_col_q, kp_col_d;
  logic [MAP_W-1:0]  raw_q, raw_d;
  logic [MAP_W-1:0]  prev_q, prev_d;
  logic [MAP_W-1:0]  deb_q, deb_d;
  logic [DW-1:0]     stable_q, stable_d;
  logic              push_q, push_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic              ovf_q, ovf_d;
  logic [MAP_W-1:0]  new_c;
  logic              sample_c;

  ctrl_t             ctrl;
  logic              flush_c, pop_ok_c, drop_c;
  logic [CW-1:0]     fifo_count;
  logic [CODE_W-1:0] fifo_head;
  logic              fifo_empty, fifo_full;
  status_t           status;
  logic              unused_ctrl;

  assign ctrl        = ctrl_t'(wr_data);
  assign unused_ctrl = ^ctrl.rsvd;
  assign flush_c     = wr_en & ctrl.flush;
  assign pop_ok_c    = rd_en & ~fifo_empty;
  // A push lost to a full FIFO; flush and same-cycle pop both excuse it.
  assign drop_c      = push_q & fifo_full & ~pop_ok_c & ~flush_c;

  // Scan, debounce and press-encoding next-state
  always_comb begin
    tick_d   = tick_q;
    col_d    = col_q;
    kp_col_d = kp_col_q;
    raw_d    = raw_q;
    prev_d   = prev_q;
    deb_d    = deb_q;
    stable_d = stable_q;
    push_d   = 1'b0;
    code_d   = code_q;
    new_c    = '0;
    sample_c = (tick_q == TICK_LAST);

    if (!sample_c) begin
      tick_d = tick_q + TW'(1);
    end else begin
      tick_d   = '0;
      col_d    = col_q + 2'd1;
      kp_col_d = ~(4'b0001 << col_d);
      for (int r = 0; r < 4; r++) begin
        raw_d[{2'(r), col_q}] = ~row_s2_q[2'(r)];
      end
      // Column 3 closes a full scan: run the stability check.
      if (col_q == 2'd3) begin
        prev_d = raw_d;
        if (raw_d == prev_q) begin
          if (stable_q < DEB_MAX) stable_d = stable_q + DW'(1);
        end else begin
          stable_d = DW'(1);
        end
        if (stable_d == DEB_MAX) begin
          deb_d = raw_d;
          new_c = raw_d & ~deb_q;
          if (new_c != '0) begin
            push_d = 1'b1;
            code_d = key_code(lowest_index(new_c));
          end
        end
      end
    end

    ovf_d = ovf_q;
    if (wr_en && ctrl.clr_ovf) ovf_d = 1'b0;
    if (drop_c)                ovf_d = 1'b1;
  end

  // State registers, including the 2-flop row synchronizer
  always_ff @(posedge clk) begin
    if (rst) begin
      row_s1_q <= 4'hF;
      row_s2_q <= 4'hF;
      tick_q   <= '0;
      col_q    <= '0;
      kp_col_q <= 4'b1110;
      raw_q    <= '0;
      prev_q   <= '0;
      deb_q    <= '0;
      stable_q <= '0;
      push_q   <= 1'b0;
      code_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      row_s1_q <= kp_row;
      row_s2_q <= row_s1_q;
      tick_q   <= tick_d;
      col_q    <= col_d;
      kp_col_q <= kp_col_d;
      raw_q    <= raw_d;
      prev_q   <= prev_d;
      deb_q    <= deb_d;
      stable_q <= stable_d;
      push_q   <= push_d;
      code_q   <= code_d;
      ovf_q    <= ovf_d;
    end
  end

  keypad_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CODE_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_i    (push_q),
    .data_i    (code_q),
    .pop_i     (rd_en),
    .flush_i   (flush_c),
    .count_c_o (fifo_count),
    .head_c_o  (fifo_head),
    .empty_c_o (fifo_empty),
    .full_c_o  (fifo_full)
  );

  // Status word assembly
  always_comb begin
    status           = '0;
    status.not_empty = ~fifo_empty;
    status.overflow  = ovf_q;
    status.count     = STAT_CNTW'(fifo_count);
    status.key_map   = deb_q;
    status.head_code = fifo_head;
  end

  assign rd_data = status;
  assign kp_col  = kp_col_q;
  assign key_irq = ~fifo_empty;

endmodule

// File: tb/tb_keypad_scanner_module.sv
// Directed bench for keypad_scanner_module with a small keypad model.
module tb_keypad_scanner_module;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [31:0] wr_data;
  logic        rd_en;
  logic [31:0] rd_data;
  logic [3:0]  kp_col;
  logic [3:0]  kp_row;
  logic        key_irq;

  logic [15:0] pressed;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;

  always #5 clk = ~clk;

  keypad_scanner_module #(
    .SCAN_TICKS     (4),
    .DEBOUNCE_SCANS (2),
    .FIFO_DEPTH     (4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .kp_col  (kp_col),
    .kp_row  (kp_row),
    .key_irq (key_irq)
  );

  // A pressed key at (r,c) pulls row r low while column c is driven low.
  always_comb begin
    kp_row = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (pressed[4'(r*4 + c)] && !kp_col[2'(c)]) kp_row[2'(r)] = 1'b0;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
    cyc += n;
  endtask

  task automatic wait_until(input int target);
    step(target - cyc);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h required 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic pop_once(input string tag, input logic [31:0] exp_before);
    rd_en = 1'b1;
    check(tag, rd_data, exp_before);
    step(1);
    rd_en = 1'b0;
  endtask

  int          seq_idx [5] = '{5, 9, 10, 13, 2};
  logic [31:0] seq_pop [4] = '{32'hC400_0005, 32'hC300_0008, 32'hC200_0009, 32'hC100_0000};

  initial begin
    rst     = 1'b1;
    wr_en   = 1'b0;
    wr_data = '0;
    rd_en   = 1'b0;
    pressed = '0;
    repeat (3) @(posedge clk);
    do_reset();

    // 1: reset state and column rotation
    check("reset_col", {28'd0, kp_col}, 32'h0000_000E);
    check("reset_rd", rd_data, 32'h0000_0000);
    check("reset_irq", {31'd0, key_irq}, 32'd0);
    step(4); check("col1", {28'd0, kp_col}, 32'h0000_000D);
    step(4); check("col2", {28'd0, kp_col}, 32'h0000_000B);
    step(4); check("col3", {28'd0, kp_col}, 32'h0000_0007);
    step(4); check("col0_wrap", {28'd0, kp_col}, 32'h0000_000E);

    // 2: held key (r1,c2) -> code 6
    pressed[6] = 1'b1;
    step(96);
    check("k6_status", rd_data, 32'h8100_4006);
    check("k6_irq", {31'd0, key_irq}, 32'd1);
    pop_once("k6_prepop", 32'h8100_4006);
    check("k6_postpop", rd_data, 32'h0000_4000);
    pressed[6] = 1'b0;
    step(96);
    check("k6_release", rd_data, 32'h0000_0000);

    // 3: bouncing (r0,c0) then stable -> exactly one code 1
    for (int i = 0; i < 5; i++) begin
      pressed[0] = ~pressed[0];
      step(3);
    end
    step(80);
    check("bounce_one", rd_data, 32'h8100_0101);
    pop_once("bounce_pop", 32'h8100_0101);
    pressed[0] = 1'b0;
    step(96);
    check("bounce_empty", rd_data, 32'h0000_0000);

    // 4: five presses into a 4-deep FIFO -> overflow
    for (int k = 0; k < 5; k++) begin
      pressed[4'(seq_idx[k])] = 1'b1;
      step(96);
      pressed = '0;
      step(96);
    end
    check("ovf_full", rd_data, 32'hC400_0005);
    for (int k = 0; k < 4; k++) begin
      pop_once($sformatf("ovf_pop%0d", k), seq_pop[k]);
    end
    check("ovf_drained", rd_data, 32'h4000_0000);
    wr_en   = 1'b1;
    wr_data = 32'h2;
    step(1);
    wr_en   = 1'b0;
    wr_data = '0;
    check("ovf_clear", rd_data, 32'h0000_0000);

    // 5: push coinciding with pop at count 2 (cycle-exact from reset)
    do_reset();
    pressed[5] = 1'b1;
    wait_until(48);  pressed[5]  = 1'b0;
    wait_until(80);  pressed[9]  = 1'b1;
    wait_until(128); pressed[9]  = 1'b0;
    wait_until(160); pressed[10] = 1'b1;
    wait_until(192);
    pop_once("pp_before", 32'h8204_0005);
    check("pp_after", rd_data, 32'h8204_0008);

    // 6: flush with three entries, then reset mid-scan
    wait_until(208); pressed[10] = 1'b0;
    wait_until(240); pressed[2]  = 1'b1;
    wait_until(272);
    check("push_lat", rd_data, 32'h8200_0408);
    step(1);
    check("three", rd_data, 32'h8300_0408);
    wr_en   = 1'b1;
    wr_data = 32'h1;
    step(1);
    wr_en   = 1'b0;
    wr_data = '0;
    check("flush_rd", rd_data, 32'h0000_0400);
    check("flush_irq", {31'd0, key_irq}, 32'd0);
    wait_until(278);
    check("mid_col", {28'd0, kp_col}, 32'h0000_000D);
    rst = 1'b1;
    step(1);
    check("rst_col", {28'd0, kp_col}, 32'h0000_000E);
    check("rst_rd", rd_data, 32'h0000_0000);
    rst     = 1'b0;
    pressed = '0;
    step(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
